// File: rtl/velocity_pkg.sv
// Shared types and constants for the velocity ramp controller: FSM states,
// the 2-bit speed level, target decode and the settle-state helper.
package velocity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RAMP_UP,
    ST_RAMP_DOWN,
    ST_STOPPED
  } state_e;

  typedef logic [1:0] speed_t;

  localparam speed_t SPD_STOP = 2'd0;
  localparam speed_t SPD_LOW  = 2'd1;
  localparam speed_t SPD_MID  = 2'd2;
  localparam speed_t SPD_HIGH = 2'd3;

  // Priority high > mid > low; anything else requests a stop.
  function automatic speed_t decode_target(input logic a, input logic b,
                                           input logic c, input logic d);
    speed_t t;
    if (a && b)                  t = SPD_HIGH;
    else if (a && !b)            t = SPD_MID;
    else if (b || (c && d))      t = SPD_LOW;
    else                         t = SPD_STOP;
    return t;
  endfunction

  function automatic state_e settle_state(input speed_t spd);
    return (spd == SPD_STOP) ? ST_IDLE : ST_HOLD;
  endfunction

endpackage

// File: rtl/velocity_pwm.sv
// Free-running PWM frame counter with a duty threshold of speed quarters
// of the frame.
module velocity_pwm
  import velocity_pkg::*;
#(
  parameter int PWM_PERIOD = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  speed_t speed,
  output logic   pwm
);

  localparam int FW = $clog2(PWM_PERIOD);
  localparam logic [FW:0] QTR = (FW + 1)'(PWM_PERIOD / 4);

  logic [FW-1:0] frame_q, frame_d;
  logic [FW:0]   thresh;

  always_comb begin
    frame_d = frame_q + 1'b1;
    if (frame_q == FW'(PWM_PERIOD - 1)) frame_d = '0;
    thresh = {{(FW - 1){1'b0}}, speed} * QTR;
    pwm    = ({1'b0, frame_q} < thresh);
  end

  always_ff @(posedge clk) begin
    if (rst) frame_q <= '0;
    else     frame_q <= frame_d;
  end

endmodule

// File: rtl/velocity_ramp_ctrl.sv
// Velocity ramp controller: registered sensor decode, dwell-paced speed ramp
// FSM with e-stop override. PWM output enabled by define VELOCITY_PWM_EN.
module velocity_ramp_ctrl
  import velocity_pkg::*;
#(
  parameter int DWELL      = 4,
  parameter int PWM_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       estop,
  output logic [1:0] speed,
  output logic       busy,
  output logic       at_target,
  output logic       pwm
);

  logic a_q, b_q, c_q, d_q, estop_q;
  logic a_d, b_d, c_d, d_d, estop_d;

  state_e     state_q, state_d;
  speed_t     speed_q, speed_d;
  logic [7:0] cnt_q, cnt_d;
  speed_t     target;
  logic       dwell_done;

  always_comb begin
    a_d     = a;
    b_d     = b;
    c_d     = c;
    d_d     = d;
    estop_d = estop;
  end

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    target     = decode_target(a_q, b_q, c_q, d_q);
    dwell_done = (cnt_q == 8'(DWELL - 1));

    if (estop_q) begin
      state_d = ST_STOPPED;
      speed_d = SPD_STOP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          cnt_d = '0;
          if (target > speed_q)      state_d = ST_RAMP_UP;
          else if (target < speed_q) state_d = ST_RAMP_DOWN;
          else                       state_d = settle_state(speed_q);
        end
        ST_RAMP_UP: begin
          if (target == speed_q) begin
            state_d = settle_state(speed_q);
            cnt_d   = '0;
          end else if (target < speed_q) begin
            state_d = ST_RAMP_DOWN;
            cnt_d   = '0;
          end else if (dwell_done) begin
            cnt_d = '0;
            if (speed_q != SPD_HIGH) speed_d = speed_q + 2'd1;
            if (speed_d == target)   state_d = settle_state(speed_d);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RAMP_DOWN: begin
          if (target == speed_q) begin
            state_d = settle_state(speed_q);
            cnt_d   = '0;
          end else if (target > speed_q) begin
            state_d = ST_RAMP_UP;
            cnt_d   = '0;
          end else if (dwell_done) begin
            cnt_d = '0;
            if (speed_q != SPD_STOP) speed_d = speed_q - 2'd1;
            if (speed_d == target)   state_d = settle_state(speed_d);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_STOPPED: begin
          // Only reached with estop_q already low, so release to IDLE.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = SPD_STOP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= 1'b0;
      estop_q <= 1'b0;
      state_q <= ST_IDLE;
      speed_q <= SPD_STOP;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      estop_q <= estop_d;
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign speed     = speed_q;
  assign busy      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign at_target = (speed_q == target) && !estop_q;

`ifdef VELOCITY_PWM_EN
  velocity_pwm #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .speed(speed_q),
    .pwm  (pwm)
  );
`else
  logic unused_pwm_cfg;
  assign unused_pwm_cfg = (PWM_PERIOD > 0);
  assign pwm = 1'b0;
`endif

endmodule

// File: doc/velocity_ramp_ctrl.md
VELOCITY_RAMP_CTRL -- requirements
Module: velocity_ramp_ctrl

Interface
- REQ-001 Parameter DWELL, default 4: clock cycles per speed step while ramping; legal range 1..255.
- REQ-002 Parameter PWM_PERIOD, default 8: PWM frame length in cycles; power of two, minimum 4.
- REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
- REQ-004 Port rst, input, 1: reset, synchronous and active-high.
- REQ-005 Ports a, b, c, d, input, 1 each: raw velocity-select sensor inputs.
- REQ-006 Port estop, input, 1: emergency stop, level-sensitive.
- REQ-007 Port speed, output, 2: current applied speed level (0 stop, 1 low, 2 mid, 3 high).
- REQ-008 Port busy, output, 1: high in RAMP_UP or RAMP_DOWN.
- REQ-009 Port at_target, output, 1: high when speed equals target and estop is low.
- REQ-010 Port pwm, output, 1: motor drive pulse train.

Function
- REQ-011 a, b, c, d and estop SHALL be registered once; all decode uses the registered copies (1-cycle input latency).
- REQ-012 Target decode, priority high>mid>low: a&b -> 3; a&~b -> 2; ~a&(b|(c&d)) -> 1; otherwise 0.
- REQ-013 States SHALL be IDLE, HOLD, RAMP_UP, RAMP_DOWN, STOPPED.
- REQ-014 IDLE/HOLD: target>speed -> RAMP_UP; target<speed -> RAMP_DOWN; equal and speed=0 -> IDLE; equal and speed>0 -> HOLD.
- REQ-015 On entry to either RAMP state the 8-bit dwell counter SHALL clear to 0.
- REQ-016 Each cycle in RAMP the counter SHALL increment; on the edge where it equals DWELL-1, speed steps by ±1 and the counter clears.
- REQ-017 After a step, if new speed equals target, next state is HOLD (IDLE if 0); otherwise the state remains RAMP.
- REQ-018 Mid-ramp target change: in RAMP_UP with target=speed -> HOLD/IDLE, no step; with target<speed -> RAMP_DOWN, counter cleared. RAMP_DOWN is symmetric.
- REQ-019 speed SHALL never wrap: no increment at 3, no decrement at 0.
- REQ-020 Registered estop high SHALL force speed=0, counter=0, state STOPPED on the next edge, overriding all other transitions.
- REQ-021 STOPPED SHALL hold while estop is high; on the first cycle estop is low, go to IDLE, then ramp normally from 0.
- REQ-022 pwm SHALL be high when frame counter < speed*PWM_PERIOD/4; the frame counter wraps at PWM_PERIOD-1 and runs freely.

Reset
- REQ-023 On rst: state IDLE, speed 0, dwell counter 0, frame counter 0, input registers 0, busy 0, at_target 1, pwm 0.
- REQ-024 rst asserted mid-ramp SHALL abandon the ramp with no further step.

Configuration
- REQ-025 Macro VELOCITY_PWM_EN defined: PWM sub-module instantiated and pwm per REQ-022.
- REQ-026 Macro VELOCITY_PWM_EN undefined: no frame counter, pwm tied to 0, all other behaviour unchanged.

Structure
- REQ-027 Package velocity_pkg SHALL hold the state enum, the 2-bit speed type, and constants SPD_STOP/LOW/MID/HIGH (0..3).
- REQ-028 Sub-module velocity_pwm (frame counter and compare) SHALL be the only sub-module.

Verification (DWELL=4, PWM_PERIOD=8, edges counted from the first edge after stimulus)
- REQ-029 Reset release, a=b=1: speed=1 after edge 5, 2 after edge 9, 3 after edge 13; busy 1 from edge 1 to 12; then HOLD with at_target=1.
- REQ-030 From speed 3, set a=1 b=0: RAMP_DOWN; speed=2 after 5 edges and stays; busy drops.
- REQ-031 Ramping 0->3, switch to a=0 b=0 c=0 d=0 when speed=1: RAMP_DOWN, counter cleared, speed 0 four edges after the reversal, then IDLE.
- REQ-032 estop pulse at speed 3 mid-hold: speed=0 two edges after estop rises; STOPPED while high; IDLE one edge after the registered estop falls, then re-ramp.
- REQ-033 speed=2 steady, PWM enabled: pwm high 4 of every 8 cycles; speed=3 gives 6 of 8; macro undefined gives pwm constant 0.
- REQ-034 rst pulse while counter=2 in RAMP_UP: all outputs at reset values the next cycle, with no speed increment.
